lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the control decoder and a handshaked data memory. It accepts one memory instruction per request, identified by the decoder's aluOP code. It drives a req/ack bus with byte strobes, aligns and extends load data, and stalls the PC while the access is in flight. Misaligned, unsupported or timed-out accesses park the block in a sticky fault state.

---
 rtl/lsu_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one decoded memory instruction into a req/ack bus
// transaction, aligns and extends load data, and parks in a sticky fault on errors.
module lsu_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        fault_clr_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LH  = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_OP    = 2'b10;
    localparam logic [1:0] CAUSE_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    function automatic logic op_supported_f(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_SB, OP_SH, OP_SW: op_supported_f = 1'b1;
            default:                                         op_supported_f = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_f(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store_f = 1'b1;
            default:             is_store_f = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned_f(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_SH: misaligned_f = off[0];
            OP_LW, OP_SW: misaligned_f = (off != 2'b00);
            default:      misaligned_f = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_f(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   wstrb_f = 4'b0001 << off;
            OP_SH:   wstrb_f = 4'b0011 << off;
            OP_SW:   wstrb_f = 4'b1111;
            default: wstrb_f = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   wdata_f = {4{d[7:0]}};
            OP_SH:   wdata_f = {2{d[15:0]}};
            OP_SW:   wdata_f = d;
            default: wdata_f = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   load_ext_f = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_ext_f = {24'h00_0000, lane[7:0]};
            OP_LH:   load_ext_f = {{16{lane[15]}}, lane[15:0]};
            default: load_ext_f = lane;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_wstrb_q, bus_wstrb_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        cause_d     = cause_q;
        case (state_q)
            S_IDLE: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (!op_supported_f(op_i)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_OP;
                end else if (misaligned_f(op_i, addr_i[1:0])) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_ALIGN;
                end else begin
                    state_d     = S_REQ;
                    cnt_d       = {CNT_W{1'b0}};
                    op_d        = op_i;
                    off_d       = addr_i[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store_f(op_i);
                    bus_addr_d  = {addr_i[31:2], 2'b00};
                    bus_wstrb_d = wstrb_f(op_i, addr_i[1:0]);
                    bus_wdata_d = wdata_f(op_i, wdata_i);
                end
            end
            S_REQ: begin
                // Ack takes priority over the timeout in the final wait cycle.
                if (bus_ack_i) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!is_store_f(op_q)) begin
                        rd_data_d = load_ext_f(op_q, off_q, bus_rdata_i);
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_FAULT;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    cause_d   = CAUSE_TMO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr_i) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            op_q        <= 6'd0;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rd_data_q   <= 32'h0000_0000;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    // Stall is combinational so the PC freezes in the same cycle the instruction is seen.
    assign stall_o = ((state_q == S_IDLE) && start_i) || (state_q == S_REQ) || (state_q == S_FAULT);

    assign done_o        = done_q;
    assign rd_data_o     = rd_data_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wstrb_o   = bus_wstrb_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: a vector table of single accesses plus
// hand-written timeout, ack-at-deadline and asynchronous-reset sequences.
module tb_lsu_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault_clr;
    logic        stall;
    logic        done;
    logic [31:0] rd_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        fault;
    logic [1:0]  fault_cause;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd;

    lsu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .op_i         (op),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .fault_clr_i  (fault_clr),
        .stall_o      (stall),
        .done_o       (done),
        .rd_data_o    (rd_data),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wstrb_o  (bus_wstrb),
        .bus_wdata_o  (bus_wdata),
        .bus_rdata_i  (bus_rdata),
        .bus_ack_i    (bus_ack),
        .fault_o      (fault),
        .fault_cause_o(fault_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  cause;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] bwdata;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_rd;
        @(negedge clk);
        start = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        #1;
        chk($sformatf("v%0d stall_c0", idx), 32'(stall), 32'd1);
        @(negedge clk);
        if (v.cause != 2'b00) begin
            chk($sformatf("v%0d fault", idx), 32'(fault), 32'd1);
            chk($sformatf("v%0d cause", idx), 32'(fault_cause), 32'(v.cause));
            chk($sformatf("v%0d no_req", idx), 32'(bus_req), 32'd0);
            start = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("v%0d stall_fault", idx), 32'(stall), 32'd1);
            chk($sformatf("v%0d fault_held", idx), 32'(fault), 32'd1);
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
            #1;
            chk($sformatf("v%0d fault_clr", idx), {29'd0, fault, fault_cause}, 32'd0);
            chk($sformatf("v%0d stall_clr", idx), 32'(stall), 32'd0);
        end else begin
            chk($sformatf("v%0d req", idx), 32'(bus_req), 32'd1);
            chk($sformatf("v%0d addr", idx), bus_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d we", idx), 32'(bus_we), 32'(v.we));
            chk($sformatf("v%0d strb", idx), 32'(bus_wstrb), 32'(v.strb));
            chk($sformatf("v%0d wdata", idx), bus_wdata, v.bwdata);
            chk($sformatf("v%0d stall_req", idx), 32'(stall), 32'd1);
            repeat (v.waits) @(negedge clk);
            chk($sformatf("v%0d req_hold", idx), {31'd0, bus_req}, 32'd1);
            chk($sformatf("v%0d addr_hold", idx), bus_addr, {v.addr[31:2], 2'b00});
            bus_ack = 1'b1; bus_rdata = v.rdata;
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = 32'h0;
            exp_rd = v.we ? last_rd : v.rd;
            chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d rd_data", idx), rd_data, exp_rd);
            chk($sformatf("v%0d req_drop", idx), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
            last_rd = exp_rd;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d done_pulse", idx), {30'd0, done, bus_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{6'd2,  32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0, 2'b00, 1'b0, 4'b0000, 32'h0,          32'hDEAD_BEEF};
        vecs[1]  = '{6'd0,  32'h0000_0103, 32'h0,          32'h80FF_0000, 3, 2'b00, 1'b0, 4'b0000, 32'h0,          32'hFFFF_FF80};
        vecs[2]  = '{6'd4,  32'h0000_0103, 32'h0,          32'h80FF_0000, 3, 2'b00, 1'b0, 4'b0000, 32'h0,          32'h0000_0080};
        vecs[3]  = '{6'd15, 32'h0000_0202, 32'h1234_5678,  32'h0,         0, 2'b00, 1'b1, 4'b0100, 32'h7878_7878,  32'h0};
        vecs[4]  = '{6'd16, 32'h0000_0202, 32'h1234_5678,  32'h0,         1, 2'b00, 1'b1, 4'b1100, 32'h5678_5678,  32'h0};
        vecs[5]  = '{6'd1,  32'h0000_0102, 32'h0,          32'h8001_1234, 1, 2'b00, 1'b0, 4'b0000, 32'h0,          32'hFFFF_8001};
        vecs[6]  = '{6'd17, 32'h0000_0300, 32'hCAFE_F00D,  32'h0,         0, 2'b00, 1'b1, 4'b1111, 32'hCAFE_F00D,  32'h0};
        vecs[7]  = '{6'd17, 32'h0000_0101, 32'h1111_1111,  32'h0,         0, 2'b01, 1'b0, 4'b0000, 32'h0,          32'h0};
        vecs[8]  = '{6'd3,  32'h0000_0100, 32'h0,          32'h0,         0, 2'b10, 1'b0, 4'b0000, 32'h0,          32'h0};
        vecs[9]  = '{6'd1,  32'h0000_0101, 32'h0,          32'h0,         0, 2'b01, 1'b0, 4'b0000, 32'h0,          32'h0};
        vecs[10] = '{6'd20, 32'h0000_0100, 32'h0,          32'h0,         0, 2'b10, 1'b0, 4'b0000, 32'h0,          32'h0};
        vecs[11] = '{6'd0,  32'h0000_0101, 32'h0,          32'h0000_7F00, 0, 2'b00, 1'b0, 4'b0000, 32'h0,          32'h0000_007F};

        rst_n = 1'b0; start = 1'b0; op = 6'd0; addr = 32'h0; wdata = 32'h0;
        fault_clr = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst bus", {bus_req, bus_we, bus_wstrb}, 32'd0);
        chk("rst addr", bus_addr, 32'h0);
        chk("rst wdata", bus_wdata, 32'h0);
        chk("rst rd_data", rd_data, 32'h0);
        chk("rst flags", {28'd0, done, fault, fault_cause}, 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: no ack ever.
        @(negedge clk);
        start = 1'b1; op = 6'd2; addr = 32'h0000_0400;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo req_cycles", 32'(n), 32'(TIMEOUT));
        chk("tmo fault", 32'(fault), 32'd1);
        chk("tmo cause", 32'(fault_cause), 32'd3);
        chk("tmo stall", 32'(stall), 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("tmo clr", {29'd0, fault, fault_cause}, 32'd0);

        // Ack arriving in the last permitted REQ cycle wins over the timeout.
        @(negedge clk);
        start = 1'b1; op = 6'd2; addr = 32'h0000_0500;
        @(negedge clk);
        start = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("late req_high", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("late done", 32'(done), 32'd1);
        chk("late no_fault", 32'(fault), 32'd0);
        chk("late rd_data", rd_data, 32'h1122_3344);

        // Asynchronous reset in the middle of REQ, with an ack left pending.
        @(negedge clk);
        start = 1'b1; op = 6'd2; addr = 32'h0000_0600;
        @(negedge clk);
        chk("arst req_before", {31'd0, bus_req}, 32'd1);
        start = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst req", 32'(bus_req), 32'd0);
        chk("arst addr", bus_addr, 32'h0);
        chk("arst rd_data", rd_data, 32'h0);
        chk("arst flags", {28'd0, done, fault, fault_cause}, 32'd0);
        chk("arst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst ack_ignored", {30'd0, bus_req, done}, 32'd0);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        last_rd = 32'h0;
        run_vec(100, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
